// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit for the execute stage.
// One shift-add (MUL/MULH) or restoring-subtract (DIV/REM) step per cycle; one result beat per op.
module muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_idix_p1,
    input  logic [1:0]       op_idix_p1,
    input  logic [WIDTH-1:0] rs_p1,
    input  logic [WIDTH-1:0] rt_p1,
    input  logic [2:0]       dest_reg_idix_p1,
    input  logic             flush_p1,
    output logic             stall_ex_p1,
    output logic             busy,
    output logic             muldiv_valid,
    output logic [WIDTH-1:0] muldiv_data,
    output logic [2:0]       muldiv_dest_reg,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [1:0]       op_q;
    logic [2:0]       dest_q;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] rt_q;
    // hi_q is the upper accumulator (MUL) or partial remainder (DIV); lo_q is multiplier / quotient.
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       dest_out_q;
    logic             dbz_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] result_d;

    always_comb begin
        mul_sum  = hi_q + (lo_q[0] ? {1'b0, rs_q} : '0);
        rem_sh   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        trial    = {1'b0, rem_sh} - {2'b00, rt_q};
        hi_d     = '0;
        lo_d     = '0;
        if (op_q[1]) begin
            // A clear sign bit on the trial subtraction means the divisor fits.
            if (!trial[WIDTH+1]) begin
                hi_d = trial[WIDTH:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_sh;
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = {1'b0, mul_sum[WIDTH:1]};
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        result_d = op_q[0] ? hi_d[WIDTH-1:0] : lo_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_q       <= '0;
            dest_q     <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            dest_out_q <= '0;
            dbz_q      <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            dest_out_q <= '0;
            dbz_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_idix_p1 && !flush_p1) begin
                        op_q    <= op_idix_p1;
                        dest_q  <= dest_reg_idix_p1;
                        rs_q    <= rs_p1;
                        rt_q    <= rt_p1;
                        count_q <= '0;
                        if (op_idix_p1[1] && (rt_p1 == '0)) begin
                            state_q    <= DONE;
                            valid_q    <= 1'b1;
                            data_q     <= op_idix_p1[0] ? rs_p1 : '1;
                            dest_out_q <= dest_reg_idix_p1;
                            dbz_q      <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            hi_q    <= '0;
                            lo_q    <= op_idix_p1[1] ? rs_p1 : rt_p1;
                        end
                    end
                end
                RUN: begin
                    if (flush_p1) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                        if (count_q == CW'(WIDTH - 1)) begin
                            state_q    <= DONE;
                            valid_q    <= 1'b1;
                            data_q     <= result_d;
                            dest_out_q <= dest_q;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (flush_p1) begin
                        count_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = (state_q != IDLE);
    assign stall_ex_p1     = rst & (((state_q == IDLE) & start_idix_p1 & ~flush_p1) | (state_q == RUN));
    assign muldiv_valid    = valid_q;
    assign muldiv_data     = data_q;
    assign muldiv_dest_reg = dest_out_q;
    assign div_by_zero     = dbz_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and random checks of muldiv_seq: results, latency, stall, flush and async reset.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start_idix_p1;
    logic [1:0]  op_idix_p1;
    logic [15:0] rs_p1;
    logic [15:0] rt_p1;
    logic [2:0]  dest_reg_idix_p1;
    logic        flush_p1;
    logic        stall_ex_p1;
    logic        busy;
    logic        muldiv_valid;
    logic [15:0] muldiv_data;
    logic [2:0]  muldiv_dest_reg;
    logic        div_by_zero;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    // Entry packing: {div_by_zero, dest_reg[2:0], data[15:0]}
    logic [19:0] exp_q[$];

    muldiv_seq #(.WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_idix_p1    (start_idix_p1),
        .op_idix_p1       (op_idix_p1),
        .rs_p1            (rs_p1),
        .rt_p1            (rt_p1),
        .dest_reg_idix_p1 (dest_reg_idix_p1),
        .flush_p1         (flush_p1),
        .stall_ex_p1      (stall_ex_p1),
        .busy             (busy),
        .muldiv_valid     (muldiv_valid),
        .muldiv_data      (muldiv_data),
        .muldiv_dest_reg  (muldiv_dest_reg),
        .div_by_zero      (div_by_zero),
        .state_dbg        (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'b0, muldiv_valid}, 32'd0);
        check({tag, "_data"},  {16'b0, muldiv_data}, 32'd0);
        check({tag, "_dest"},  {29'b0, muldiv_dest_reg}, 32'd0);
        check({tag, "_dbz"},   {31'b0, div_by_zero}, 32'd0);
        check({tag, "_busy"},  {31'b0, busy}, 32'd0);
        check({tag, "_stall"}, {31'b0, stall_ex_p1}, 32'd0);
    endtask

    // Issue one op, push the reference result, then wait (bounded) for the strobe.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] dest, input bit hold);
        logic [31:0] prod;
        logic [15:0] res;
        logic        dbz;
        int          lat;
        bit          seen;
        logic [19:0] got;
        prod = {16'b0, a} * {16'b0, b};
        dbz  = 1'b0;
        lat  = 17;
        case (op)
            2'b00: res = prod[15:0];
            2'b01: res = prod[31:16];
            2'b10: res = (b == 16'd0) ? 16'hFFFF : a / b;
            default: res = (b == 16'd0) ? a : a % b;
        endcase
        if (op[1] && b == 16'd0) begin
            dbz = 1'b1;
            lat = 1;
        end
        exp_q.push_back({dbz, dest, res});

        @(negedge clk);
        start_idix_p1    = 1'b1;
        op_idix_p1       = op;
        rs_p1            = a;
        rt_p1            = b;
        dest_reg_idix_p1 = dest;
        #1 check("stall_accept", {31'b0, stall_ex_p1}, 32'd1);
        seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            if (!hold) start_idix_p1 = 1'b0;
            #1;
            if (muldiv_valid) begin
                seen = 1'b1;
                got  = {div_by_zero, muldiv_dest_reg, muldiv_data};
                check("latency", cyc, lat);
                check("result", {12'b0, got}, {12'b0, exp_q.pop_front()});
                check("stall_done", {31'b0, stall_ex_p1}, 32'd0);
            end else if (cyc < lat) begin
                check("stall_run", {31'b0, stall_ex_p1}, 32'd1);
            end
        end
        check("valid_seen", {31'b0, seen}, 32'd1);
        if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        start_idix_p1 = 1'b0;
        #1;
        check("idle_after_done", {31'b0, busy}, 32'd0);
        check("valid_one_beat", {31'b0, muldiv_valid}, 32'd0);
    endtask

    initial begin
        bit any_valid;
        rst              = 1'b0;
        start_idix_p1    = 1'b0;
        op_idix_p1       = 2'b00;
        rs_p1            = 16'd0;
        rt_p1            = 16'd0;
        dest_reg_idix_p1 = 3'd0;
        flush_p1         = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        check("reset_state", {30'b0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(2'b00, 16'h0003, 16'h0005, 3'd1, 1'b0);
        run_op(2'b00, 16'hFFFF, 16'hFFFF, 3'd2, 1'b0);
        run_op(2'b01, 16'hFFFF, 16'hFFFF, 3'd3, 1'b0);
        run_op(2'b10, 16'h0064, 16'h0007, 3'd4, 1'b0);
        run_op(2'b11, 16'h0064, 16'h0007, 3'd5, 1'b0);
        run_op(2'b10, 16'h0005, 16'h0009, 3'd6, 1'b0);
        run_op(2'b11, 16'h0005, 16'h0009, 3'd7, 1'b0);
        run_op(2'b10, 16'h1234, 16'h0000, 3'd6, 1'b0);
        run_op(2'b11, 16'h1234, 16'h0000, 3'd5, 1'b0);
        run_op(2'b10, 16'hFFFF, 16'h0001, 3'd3, 1'b0);
        // Uop held on the inputs through DONE must not be re-accepted.
        run_op(2'b01, 16'h1234, 16'h5678, 3'd2, 1'b1);
        run_op(2'b11, 16'hBEEF, 16'h0000, 3'd4, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_op(2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)),
                   16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)), 1'b0);
        end

        // Flush a MUL in RUN at cycle 5.
        @(negedge clk);
        start_idix_p1    = 1'b1;
        op_idix_p1       = 2'b00;
        rs_p1            = 16'h00FF;
        rt_p1            = 16'h0101;
        dest_reg_idix_p1 = 3'd1;
        @(negedge clk);
        start_idix_p1 = 1'b0;
        repeat (4) @(negedge clk);
        flush_p1 = 1'b1;
        #1 check("flush_busy_c5", {31'b0, busy}, 32'd1);
        @(negedge clk);
        flush_p1 = 1'b0;
        #1;
        check("flush_busy_c6", {31'b0, busy}, 32'd0);
        check("flush_stall_c6", {31'b0, stall_ex_p1}, 32'd0);
        check("flush_state_c6", {30'b0, state_dbg}, 32'd0);
        any_valid = muldiv_valid;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1 any_valid = any_valid | muldiv_valid;
        end
        check("flush_no_strobe", {31'b0, any_valid}, 32'd0);
        run_op(2'b00, 16'h0007, 16'h0009, 3'd5, 1'b0);

        // Async reset at cycle 8 of a DIV.
        @(negedge clk);
        start_idix_p1    = 1'b1;
        op_idix_p1       = 2'b10;
        rs_p1            = 16'hABCD;
        rt_p1            = 16'h0013;
        dest_reg_idix_p1 = 3'd7;
        @(negedge clk);
        start_idix_p1 = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1 check_all_zero("midop_reset");
        check("midop_reset_state", {30'b0, state_dbg}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(2'b00, 16'h0002, 16'h0003, 3'd3, 1'b0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
